// File: rtl/decode_stage.sv
// RV32I ALU-instruction decode / operand-fetch stage with a 32x32 register file.
// One-deep output register behind a valid/ready handshake; write-back bypasses into capture.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_Z  = 7'h00;
  localparam logic [6:0] F7_A  = 7'h20;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  localparam dec_t DEC_RST = '{op1: '0, op2: '0, alu_op: ALU_ADD, rd: '0, rd_we: 1'b0, illegal: 1'b0};

  logic [XLEN-1:0] regs [NREGS];
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, op2_val;
  logic [3:0]      alu;
  logic            legal, wb_hit;
  dec_t            nxt, q;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign wb_hit = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back wins over the stored value so capture never sees stale data.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (wb_hit && wb_addr == rs1) ? wb_data : regs[rs1];
    if (rs2 != '0) rs2_val = (wb_hit && wb_addr == rs2) ? wb_data : regs[rs2];
  end

  always_comb begin
    legal   = 1'b0;
    alu     = ALU_ADD;
    op2_val = rs2_val;
    if (opc == OPC_R) begin
      legal = 1'b1;
      case ({f7, f3})
        {F7_Z, 3'b000}: alu = ALU_ADD;
        {F7_A, 3'b000}: alu = ALU_SUB;
        {F7_Z, 3'b111}: alu = ALU_AND;
        {F7_Z, 3'b110}: alu = ALU_OR;
        {F7_Z, 3'b100}: alu = ALU_XOR;
        {F7_Z, 3'b001}: alu = ALU_SLL;
        {F7_Z, 3'b101}: alu = ALU_SRL;
        {F7_A, 3'b101}: alu = ALU_SRA;
        {F7_Z, 3'b010}: alu = ALU_SLT;
        default:        legal = 1'b0;
      endcase
    end else if (opc == OPC_I) begin
      op2_val = {{(XLEN-12){instr[31]}}, instr[31:20]};
      legal   = 1'b1;
      case (f3)
        3'b000: alu = ALU_ADD;
        3'b111: alu = ALU_AND;
        3'b110: alu = ALU_OR;
        3'b100: alu = ALU_XOR;
        3'b010: alu = ALU_SLT;
        3'b001: begin
          alu     = ALU_SLL;
          legal   = (f7 == F7_Z);
          op2_val = {{(XLEN-5){1'b0}}, instr[24:20]};
        end
        3'b101: begin
          alu     = (f7 == F7_A) ? ALU_SRA : ALU_SRL;
          legal   = (f7 == F7_Z) || (f7 == F7_A);
          op2_val = {{(XLEN-5){1'b0}}, instr[24:20]};
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Illegal ops still flow through as a harmless ADD 0,0 with no write-back.
  always_comb begin
    nxt         = DEC_RST;
    nxt.rd      = instr[11:7];
    nxt.illegal = !legal;
    if (legal) begin
      nxt.op1    = rs1_val;
      nxt.op2    = op2_val;
      nxt.alu_op = alu;
      nxt.rd_we  = (instr[11:7] != '0);
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      q         <= DEC_RST;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      q         <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign op1     = q.op1;
  assign op2     = q.op2;
  assign alu_op  = q.alu_op;
  assign rd      = q.rd;
  assign rd_we   = q.rd_we;
  assign illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected operands,
// a negedge monitor pops and compares on every output transfer.
module tb_decode_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, op1, op2, wb_data;
  logic [3:0]  alu_op;
  logic [4:0]  rd, wb_addr;
  logic        rd_we, illegal, wb_en;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .alu_op(alu_op),
    .rd(rd), .rd_we(rd_we), .illegal(illegal), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] alu,
                              logic [4:0] r, logic we, logic ill);
    exp_t e;
    e.op1 = a; e.op2 = b; e.alu = alu; e.rd = r; e.we = we; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3, logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(logic [11:0] imm, logic [4:0] s1, logic [2:0] f3,
                                        logic [4:0] d);
    return {imm, s1, f3, d, 7'b0010011};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, expv);
    end
  endtask

  // rd is don't-care for illegal ops
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output op1=%h op2=%h alu=%b rd=%0d", op1, op2, alu_op, rd);
      end else begin
        mon_e = exp_q.pop_front();
        if (op1 !== mon_e.op1 || op2 !== mon_e.op2 || alu_op !== mon_e.alu ||
            rd_we !== mon_e.we || illegal !== mon_e.ill || (!mon_e.ill && rd !== mon_e.rd)) begin
          failures++;
          $display("FAIL txn got op1=%h op2=%h alu=%b rd=%0d we=%b ill=%b expected op1=%h op2=%h alu=%b rd=%0d we=%b ill=%b",
                   op1, op2, alu_op, rd, rd_we, illegal,
                   mon_e.op1, mon_e.op2, mon_e.alu, mon_e.rd, mon_e.we, mon_e.ill);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(logic [4:0] a, logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic send(logic [31:0] ins, exp_t e, bit push);
    int n;
    n = 0;
    in_valid = 1'b1;
    instr = ins;
    if (push) exp_q.push_back(e);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout got in_ready=0 expected in_ready=1");
    end
    step();
    in_valid = 1'b0;
  endtask

  logic [6:0] r_f7  [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [2:0] r_f3  [8] = '{3'b000, 3'b101, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [3:0] r_alu [8] = '{4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b0101, 4'b1001, 4'b1000, 4'b0100};

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'h2);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_rd_we", {31'b0, rd_we}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);

    // reset while an op is held
    wb(5'd5, 32'h0000_1234);
    out_ready = 1'b0;
    send(rtype(7'h00, 5'd0, 5'd5, 3'b000, 5'd7), '0, 1'b0);
    chk("held_valid", {31'b0, out_valid}, 32'd1);
    chk("held_op1", op1, 32'h0000_1234);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_alu", {28'b0, alu_op}, 32'h2);
    chk("async_rst_op1", op1, 32'h0);
    exp_q.delete();
    #3 rst = 1'b1;
    step();
    out_ready = 1'b1;
    send(rtype(7'h00, 5'd0, 5'd5, 3'b000, 5'd7), mk(32'h0, 32'h0, 4'b0010, 5'd7, 1'b1, 1'b0), 1'b1);

    // R/I-type decode, back-to-back
    wb(5'd1, 32'h0000_0007);
    wb(5'd2, 32'hFFFF_FFFD);
    send(32'h402081B3, mk(32'h7, 32'hFFFF_FFFD, 4'b0110, 5'd3, 1'b1, 1'b0), 1'b1);
    send(32'hFFF00213, mk(32'h0, 32'hFFFF_FFFF, 4'b0010, 5'd4, 1'b1, 1'b0), 1'b1);
    send(32'h4030D293, mk(32'h7, 32'h3, 4'b1010, 5'd5, 1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 8; i++)
      send(rtype(r_f7[i], 5'd2, 5'd1, r_f3[i], 5'd8),
           mk(32'h7, 32'hFFFF_FFFD, r_alu[i], 5'd8, 1'b1, 1'b0), 1'b1);
    send(itype(12'h7FF, 5'd2, 3'b111, 5'd9), mk(32'hFFFF_FFFD, 32'h7FF, 4'b0000, 5'd9, 1'b1, 1'b0), 1'b1);
    send(itype(12'hFFE, 5'd1, 3'b010, 5'd10), mk(32'h7, 32'hFFFF_FFFE, 4'b0100, 5'd10, 1'b1, 1'b0), 1'b1);
    send(itype(12'h01F, 5'd1, 3'b001, 5'd11), mk(32'h7, 32'h1F, 4'b1001, 5'd11, 1'b1, 1'b0), 1'b1);
    send(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), mk(32'h7, 32'hFFFF_FFFD, 4'b0010, 5'd0, 1'b0, 1'b0), 1'b1);

    // stall: outputs frozen, write-back lands but held op1 keeps old value
    step(); step();
    out_ready = 1'b0;
    send(itype(12'h010, 5'd1, 3'b100, 5'd12), mk(32'h7, 32'h10, 4'b0101, 5'd12, 1'b1, 1'b0), 1'b1);
    in_valid = 1'b1;
    instr = itype(12'h0F0, 5'd1, 3'b110, 5'd13);
    exp_q.push_back(mk(32'h0000_DEAD, 32'hF0, 4'b0001, 5'd13, 1'b1, 1'b0));
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_DEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_op1", op1, 32'h7);
      chk("stall_op2", op2, 32'h10);
      step();
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("no_bubble_valid", {31'b0, out_valid}, 32'd1);

    // bypass and x0 write
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hA5A5_A5A5;
    send(rtype(7'h00, 5'd1, 5'd1, 3'b000, 5'd6), mk(32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0010, 5'd6, 1'b1, 1'b0), 1'b1);
    wb_en = 1'b0;
    wb(5'd0, 32'h5);
    send(rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd14), mk(32'h0, 32'h0, 4'b0010, 5'd14, 1'b1, 1'b0), 1'b1);
    send(rtype(7'h00, 5'd0, 5'd1, 3'b000, 5'd15), mk(32'hA5A5_A5A5, 32'h0, 4'b0010, 5'd15, 1'b1, 1'b0), 1'b1);

    // illegal encodings
    send(32'h0000006F, mk(32'h0, 32'h0, 4'b0010, 5'd0, 1'b0, 1'b1), 1'b1);
    send(rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd3), mk(32'h0, 32'h0, 4'b0010, 5'd3, 1'b0, 1'b1), 1'b1);
    send(rtype(7'h20, 5'd2, 5'd1, 3'b111, 5'd3), mk(32'h0, 32'h0, 4'b0010, 5'd3, 1'b0, 1'b1), 1'b1);
    send(itype(12'h405, 5'd1, 3'b001, 5'd9), mk(32'h0, 32'h0, 4'b0010, 5'd9, 1'b0, 1'b1), 1'b1);
    send(32'h12345037, mk(32'h0, 32'h0, 4'b0010, 5'd0, 1'b0, 1'b1), 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
    step();
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
